// File: rtl/muldiv_sequencer.sv
// ============================================================================
// muldiv_sequencer : sequences the shared MULT/DIV units and owns HI/LO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic        mult_start,
   output logic        mult_signed,
   input  logic        mult_busy,
   input  logic [63:0] mult_z,
   output logic        div_start,
   output logic        div_signed,
   input  logic        div_busy,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        ready,
   output logic        stall,
   output logic        done,
   output logic        div_zero,
   output logic        timeout
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_ARM   = 3'd2,
      S_WAIT  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t         state_q;
   logic [31:0]    op_a_q, op_b_q, hi_q, lo_q;
   logic           is_div_q, mult_signed_q, div_signed_q;
   logic           mult_start_q, div_start_q;
   logic           done_q, div_zero_q, timeout_q;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  cnt_d;
   logic           w_busy;

   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      w_busy = is_div_q ? div_busy : mult_busy;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         op_a_q        <= '0;
         op_b_q        <= '0;
         hi_q          <= '0;
         lo_q          <= '0;
         is_div_q      <= 1'b0;
         mult_signed_q <= 1'b0;
         div_signed_q  <= 1'b0;
         mult_start_q  <= 1'b0;
         div_start_q   <= 1'b0;
         done_q        <= 1'b0;
         div_zero_q    <= 1'b0;
         timeout_q     <= 1'b0;
         cnt_q         <= '0;
      end else begin
         mult_start_q <= 1'b0;
         div_start_q  <= 1'b0;
         done_q       <= 1'b0;
         div_zero_q   <= 1'b0;
         timeout_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (op_valid) begin
                  case (op_code)
                     OP_MTHI: begin
                        hi_q   <= rs_data;
                        done_q <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo_q   <= rs_data;
                        done_q <= 1'b1;
                     end
                     OP_MULT, OP_MULTU: begin
                        op_a_q        <= rs_data;
                        op_b_q        <= rt_data;
                        is_div_q      <= 1'b0;
                        mult_signed_q <= (op_code == OP_MULT);
                        div_signed_q  <= 1'b0;
                        mult_start_q  <= 1'b1;
                        state_q       <= S_START;
                     end
                     OP_DIV, OP_DIVU: begin
                        // A zero divisor never reaches the unit.
                        if (rt_data == 32'd0) begin
                           div_zero_q <= 1'b1;
                           done_q     <= 1'b1;
                        end else begin
                           op_a_q        <= rs_data;
                           op_b_q        <= rt_data;
                           is_div_q      <= 1'b1;
                           div_signed_q  <= (op_code == OP_DIV);
                           mult_signed_q <= 1'b0;
                           div_start_q   <= 1'b1;
                           state_q       <= S_START;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_START: state_q <= S_ARM;
            S_ARM: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (!w_busy) begin
                  state_q <= S_WRITE;
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                     timeout_q <= 1'b1;
                     done_q    <= 1'b1;
                     state_q   <= S_IDLE;
                  end
               end
            end
            S_WRITE: begin
               if (is_div_q) begin
                  lo_q <= div_q;
                  hi_q <= div_r;
               end else begin
                  hi_q <= mult_z[63:32];
                  lo_q <= mult_z[31:0];
               end
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign mult_start  = mult_start_q;
   assign mult_signed = mult_signed_q;
   assign div_start   = div_start_q;
   assign div_signed  = div_signed_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign ready       = (state_q == S_IDLE);
   assign stall       = (state_q != S_IDLE);
   assign done        = done_q;
   assign div_zero    = div_zero_q;
   assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// tb_muldiv_sequencer : randomized self-checking bench with MULT/DIV unit models.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] rs_data, rt_data;
   logic [31:0] op_a, op_b;
   logic        mult_start, mult_signed, mult_busy;
   logic [63:0] mult_z;
   logic        div_start, div_signed, div_busy;
   logic [31:0] div_q, div_r;
   logic [31:0] hi, lo;
   logic        ready, stall, done, div_zero, timeout;

   int          total = 0;
   int          bad = 0;
   int          lat = 0;
   logic        stuck = 1'b0;
   int          m_cnt, d_cnt;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
      .rs_data(rs_data), .rt_data(rt_data), .op_a(op_a), .op_b(op_b),
      .mult_start(mult_start), .mult_signed(mult_signed), .mult_busy(mult_busy),
      .mult_z(mult_z), .div_start(div_start), .div_signed(div_signed),
      .div_busy(div_busy), .div_q(div_q), .div_r(div_r), .hi(hi), .lo(lo),
      .ready(ready), .stall(stall), .done(done), .div_zero(div_zero),
      .timeout(timeout)
   );

   function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
      logic signed [63:0] sa, sb;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return sa * sb;
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   // returns {remainder, quotient}
   function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
      logic signed [31:0] q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
         return {r, q};
      end
      return {a % b, a / b};
   endfunction

   // External unit models: busy covers the ARM cycle plus 'lat' WAIT cycles.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt  <= 0;
         d_cnt  <= 0;
         mult_z <= '0;
         div_q  <= '0;
         div_r  <= '0;
      end else begin
         if (m_cnt > 0) m_cnt <= m_cnt - 1;
         if (d_cnt > 0) d_cnt <= d_cnt - 1;
         if (mult_start) begin
            m_cnt  <= lat + 1;
            mult_z <= mul64(op_a, op_b, mult_signed);
         end
         if (div_start) begin
            d_cnt          <= lat + 1;
            {div_r, div_q} <= div64(op_a, op_b, div_signed);
         end
      end
   end

   assign mult_busy = (m_cnt > 0) | stuck;
   assign div_busy  = (d_cnt > 0);

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input int l);
      logic        is_mul, is_div, dz, sign_ok;
      logic [31:0] eh, el;
      int          k, sm, sd;
      is_mul  = (code == 3'd1) || (code == 3'd2);
      is_div  = (code == 3'd3) || (code == 3'd4);
      dz      = is_div && (b == 32'd0);
      eh      = hi_m;
      el      = lo_m;
      sign_ok = 1'b1;
      sm      = 0;
      sd      = 0;
      case (code)
         3'd1: {eh, el} = mul64(a, b, 1'b1);
         3'd2: {eh, el} = mul64(a, b, 1'b0);
         3'd3: if (!dz) {eh, el} = div64(a, b, 1'b1);
         3'd4: if (!dz) {eh, el} = div64(a, b, 1'b0);
         3'd5: eh = a;
         3'd6: el = a;
         default: ;
      endcase
      lat = l;
      @(negedge clk);
      op_valid = 1'b1; op_code = code; rs_data = a; rt_data = b;
      @(posedge clk);
      #1 op_valid = 1'b0;
      if ((is_mul || is_div) && !dz) begin
         for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (mult_start) sm++;
            if (div_start) sd++;
            if (k == 1) check("stall_busy", 64'(stall), 64'd1);
            if (stall && is_mul && (mult_signed !== (code == 3'd1))) sign_ok = 1'b0;
            if (stall && is_div && (div_signed !== (code == 3'd3))) sign_ok = 1'b0;
            if (done) break;
         end
         check("latency", 64'(k), 64'(l + 5));
         check("mult_starts", 64'(sm), 64'(is_mul));
         check("div_starts", 64'(sd), 64'(is_div));
         check("signed_held", 64'(sign_ok), 64'd1);
         check("ready_after", 64'(ready), 64'd1);
      end else begin
         @(negedge clk);
         check("done_1cyc", 64'(done), 64'((code == 3'd5) || (code == 3'd6) || dz));
         check("div_zero", 64'(div_zero), 64'(dz));
         check("no_stall", 64'(stall), 64'd0);
         check("no_start", 64'({mult_start, div_start}), 64'd0);
      end
      check("hi", 64'(hi), 64'(eh));
      check("lo", 64'(lo), 64'(el));
      hi_m = eh;
      lo_m = el;
   endtask

   initial begin
      int          k;
      logic [2:0]  c;
      logic [31:0] a, b;
      rst = 1'b0; op_valid = 1'b0; op_code = '0; rs_data = '0; rt_data = '0;
      repeat (2) @(negedge clk);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_rdy_stall", 64'({ready, stall}), 64'b10);
      check("rst_pulses", 64'({done, div_zero, timeout, mult_start, div_start}), 64'd0);
      rst = 1'b1;

      run_op(3'd1, 32'hFFFF3F3F, 32'hFFFF7F7F, 3);
      check("mult_vec", {hi, lo}, 64'h00000000_60C1A141);
      run_op(3'd2, 32'h00000111, 32'h00000777, 0);
      check("multu_vec", {hi, lo}, 64'h00000000_0007F5E7);
      run_op(3'd3, 32'hFFFFFF9C, 32'h00000007, 2);
      check("div_vec", {hi, lo}, 64'hFFFFFFFE_FFFFFFF2);
      run_op(3'd4, 32'd100, 32'd7, 5);
      check("divu_vec", {hi, lo}, 64'h00000002_0000000E);
      run_op(3'd4, 32'd55, 32'd0, 1);
      run_op(3'd5, 32'hDEADBEEF, 32'd0, 0);
      check("mthi_vec", 64'(hi), 64'hDEADBEEF);
      run_op(3'd0, 32'h11111111, 32'd3, 0);
      run_op(3'd7, 32'h22222222, 32'd3, 0);

      // Asynchronous reset in the middle of WAIT.
      lat = 5;
      @(negedge clk);
      op_valid = 1'b1; op_code = 3'd1; rs_data = 32'd9; rt_data = 32'd9;
      @(posedge clk);
      #1 op_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_hilo", {hi, lo}, 64'd0);
      check("midrst_rdy_stall", 64'({ready, stall}), 64'b10);
      check("midrst_pulses", 64'({done, timeout, mult_start}), 64'd0);
      hi_m = '0; lo_m = '0;
      @(negedge clk);
      rst = 1'b1;

      // Stuck MULT busy: abort after TO cycles in WAIT; requests during stall ignored.
      run_op(3'd6, 32'hCAFEF00D, 32'd0, 0);
      stuck = 1'b1; lat = 0;
      @(negedge clk);
      op_valid = 1'b1; op_code = 3'd1; rs_data = 32'd3; rt_data = 32'd4;
      @(posedge clk);
      #1 op_code = 3'd5; rs_data = 32'h12345678;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) break;
      end
      op_valid = 1'b0;
      check("to_latency", 64'(k), 64'(TO + 3));
      check("to_pulse", 64'(timeout), 64'd1);
      check("to_hilo", {hi, lo}, {hi_m, lo_m});
      check("to_ready", 64'(ready), 64'd1);
      stuck = 1'b0;
      @(negedge clk);
      check("to_one_pulse", 64'({timeout, done}), 64'd0);

      for (int i = 0; i < 40; i++) begin
         c = 3'($urandom_range(0, 7));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         run_op(c, a, b, $urandom_range(0, 5));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
